hack_cpu_mc: RTL and testbench

Multi-cycle, parametrised Hack CPU core with explicit handshakes on separate instruction and data memory ports. It replaces the single-cycle core between the instruction ROM and the data RAM/memory-map bus, which can now insert wait states. It adds three behaviours the single-cycle core lacks: read-modify-write sequencing, stall tolerance and halt detection. Instruction semantics match the Hack ISA at DATA_W=16.

---
 rtl/hack_pkg.sv | 28 ++
 rtl/hack_alu.sv | 27 ++
 rtl/hack_cpu_mc.sv | 158 +++++++++++++++
 tb/tb_hack_cpu_mc.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared types and instruction-field constants for the multi-cycle Hack core.
package hack_pkg;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_EXEC,
      ST_RD,
      ST_WR,
      ST_HALT
   } state_e;

   // TYPE_BIT is the MSB position at DATA_W=16; the core itself uses DATA_W-1.
   localparam int TYPE_BIT = 15;
   localparam int A_BIT    = 12;
   localparam int COMP_LSB = 6;
   localparam int DEST_LSB = 3;
   localparam int JMP_LSB  = 0;

   localparam logic [2:0] JMP_NONE = 3'b000;
   localparam logic [2:0] JMP_JGT  = 3'b001;
   localparam logic [2:0] JMP_JEQ  = 3'b010;
   localparam logic [2:0] JMP_JGE  = 3'b011;
   localparam logic [2:0] JMP_JLT  = 3'b100;
   localparam logic [2:0] JMP_JNE  = 3'b101;
   localparam logic [2:0] JMP_JLE  = 3'b110;
   localparam logic [2:0] JMP_JMP  = 3'b111;

endpackage

// File: rtl/hack_alu.sv
// Combinational Hack ALU: zx/nx/zy/ny/f/no applied to x and y at DATA_W bits.
module hack_alu #(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] y,
   input  logic [5:0]        comp,
   output logic [DATA_W-1:0] out,
   output logic              zr,
   output logic              ng
);

   logic [DATA_W-1:0] x1, x2, y1, y2, f;

   always_comb begin
      x1  = comp[5] ? '0 : x;
      x2  = comp[4] ? ~x1 : x1;
      y1  = comp[3] ? '0 : y;
      y2  = comp[2] ? ~y1 : y1;
      f   = comp[1] ? (x2 + y2) : (x2 & y2);
      out = comp[0] ? ~f : f;
   end

   assign zr = (out == '0);
   assign ng = out[DATA_W-1];

endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU with handshaked instruction and data ports.
// state | meaning
// FETCH | request instruction at pc, latch into IR on instr_valid
// EXEC  | decode IR; commit directly or start a data access
// RD    | read M at A, latch MDR on mem_ready
// WR    | write ALU result to M at A, commit on mem_ready
// HALT  | self-jump detected; idle until reset
module hack_cpu_mc
   import hack_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 15,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              instr_req,
   output logic [ADDR_W-1:0] instr_addr,
   input  logic              instr_valid,
   input  logic [DATA_W-1:0] instr,
   output logic              mem_req,
   output logic              readM,
   output logic              writeM,
   output logic [ADDR_W-1:0] addressM,
   output logic [DATA_W-1:0] outM,
   input  logic [DATA_W-1:0] inM,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] ir_q, ir_d, mdr_q, mdr_d, a_q, a_d, d_q, d_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              run_q;

   logic              is_c, a_sel, d1, d2, d3, taken, commit;
   logic [2:0]        jmp;
   logic [DATA_W-1:0] alu_y, alu_out;
   logic              alu_zr, alu_ng;

   assign is_c  = ir_q[DATA_W-1];
   assign a_sel = ir_q[A_BIT];
   assign d1    = ir_q[DEST_LSB+2];
   assign d2    = ir_q[DEST_LSB+1];
   assign d3    = ir_q[DEST_LSB];
   assign jmp   = ir_q[JMP_LSB +: 3];

   // In RD the ALU must see the incoming word so a read-only op can commit on mem_ready.
   assign alu_y = !a_sel ? a_q : ((state_q == ST_RD) ? inM : mdr_q);

   hack_alu #(.DATA_W(DATA_W)) u_alu (
      .x    (d_q),
      .y    (alu_y),
      .comp (ir_q[COMP_LSB +: 6]),
      .out  (alu_out),
      .zr   (alu_zr),
      .ng   (alu_ng)
   );

   always_comb begin
      unique case (jmp)
         JMP_NONE: taken = 1'b0;
         JMP_JGT:  taken = !alu_ng && !alu_zr;
         JMP_JEQ:  taken = alu_zr;
         JMP_JGE:  taken = !alu_ng;
         JMP_JLT:  taken = alu_ng;
         JMP_JNE:  taken = !alu_zr;
         JMP_JLE:  taken = alu_ng || alu_zr;
         default:  taken = 1'b1;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      mdr_d     = mdr_q;
      a_d       = a_q;
      d_d       = d_q;
      pc_d      = pc_q;
      commit    = 1'b0;
      instr_req = 1'b0;
      mem_req   = 1'b0;
      readM     = 1'b0;
      writeM    = 1'b0;
      outM      = '0;

      case (state_q)
         ST_FETCH: begin
            instr_req = run_q;
            if (run_q && instr_valid) begin
               ir_d    = instr;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (is_c && a_sel)   state_d = ST_RD;
            else if (is_c && d3) state_d = ST_WR;
            else                 commit  = 1'b1;
         end
         ST_RD: begin
            mem_req = 1'b1;
            readM   = 1'b1;
            if (mem_ready) begin
               mdr_d = inM;
               if (d3) state_d = ST_WR;
               else    commit  = 1'b1;
            end
         end
         ST_WR: begin
            mem_req = 1'b1;
            writeM  = 1'b1;
            outM    = alu_out;
            if (mem_ready) commit = 1'b1;
         end
         default: ;
      endcase

      if (commit) begin
         state_d = ST_FETCH;
         if (!is_c) begin
            a_d  = DATA_W'(ir_q[DATA_W-2:0]);
            pc_d = pc_q + ADDR_W'(1);
         end else begin
            if (d1) a_d = alu_out;
            if (d2) d_d = alu_out;
            pc_d = taken ? a_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
            if (jmp == JMP_JMP && a_q[ADDR_W-1:0] == pc_q) state_d = ST_HALT;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_FETCH;
         ir_q    <= '0;
         mdr_q   <= '0;
         a_q     <= '0;
         d_q     <= '0;
         pc_q    <= ADDR_W'(RESET_PC);
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         mdr_q   <= mdr_d;
         a_q     <= a_d;
         d_q     <= d_d;
         pc_q    <= pc_d;
         run_q   <= 1'b1;
      end
   end

   assign instr_addr = pc_q;
   assign pc         = pc_q;
   assign addressM   = a_q[ADDR_W-1:0];
   assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Bench for hack_cpu_mc: directed scenarios plus random programs against an ISA-level model.
module tb_hack_cpu_mc;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        instr_valid = 1'b0;
   logic [15:0] instr_drv = '0;
   logic [15:0] inM = '0;
   logic        mem_ready = 1'b0;
   logic        instr_req, mem_req, readM, writeM, halted;
   logic [14:0] instr_addr, addressM, pc;
   logic [15:0] outM;

   hack_cpu_mc dut (
      .clk         (clk),
      .reset       (reset),
      .instr_req   (instr_req),
      .instr_addr  (instr_addr),
      .instr_valid (instr_valid),
      .instr       (instr_drv),
      .mem_req     (mem_req),
      .readM       (readM),
      .writeM      (writeM),
      .addressM    (addressM),
      .outM        (outM),
      .inM         (inM),
      .mem_ready   (mem_ready),
      .pc          (pc),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   localparam logic [5:0] C_ZERO = 6'b101010, C_ONE = 6'b111111, C_NEG1 = 6'b111010;
   localparam logic [5:0] C_X = 6'b001100, C_Y = 6'b110000, C_NOTX = 6'b001101;
   localparam logic [5:0] C_NOTY = 6'b110001, C_NEGX = 6'b001111, C_NEGY = 6'b110011;
   localparam logic [5:0] C_XP1 = 6'b011111, C_YP1 = 6'b110111, C_XM1 = 6'b001110;
   localparam logic [5:0] C_YM1 = 6'b110010, C_XPY = 6'b000010, C_XMY = 6'b010011;
   localparam logic [5:0] C_YMX = 6'b000111, C_XAY = 6'b000000, C_XOY = 6'b010101;

   logic [5:0] comps [18] = '{C_ZERO, C_ONE, C_NEG1, C_X, C_Y, C_NOTX, C_NOTY, C_NEGX, C_NEGY,
                              C_XP1, C_YP1, C_XM1, C_YM1, C_XPY, C_XMY, C_YMX, C_XAY, C_XOY};

   int n_pass = 0;
   int n_total = 0;

   // ISA-level architectural state
   logic [15:0] mA, mD;
   logic [14:0] mpc;
   logic        mhalt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [15:0] cinst(input logic a, input logic [5:0] c,
                                         input logic [2:0] dst, input logic [2:0] j);
      return {3'b111, a, c, dst, j};
   endfunction

   function automatic logic [15:0] ainst(input logic [14:0] v);
      return {1'b0, v};
   endfunction

   // Hack mnemonic semantics, x = D, y = A or M
   function automatic logic [15:0] comp_f(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
      case (c)
         C_ZERO: return 16'd0;
         C_ONE:  return 16'd1;
         C_NEG1: return 16'hFFFF;
         C_X:    return x;
         C_Y:    return y;
         C_NOTX: return ~x;
         C_NOTY: return ~y;
         C_NEGX: return 16'd0 - x;
         C_NEGY: return 16'd0 - y;
         C_XP1:  return x + 16'd1;
         C_YP1:  return y + 16'd1;
         C_XM1:  return x - 16'd1;
         C_YM1:  return y - 16'd1;
         C_XPY:  return x + y;
         C_XMY:  return x - y;
         C_YMX:  return y - x;
         C_XAY:  return x & y;
         C_XOY:  return x | y;
         default: return 16'd0;
      endcase
   endfunction

   function automatic logic jump_f(input logic [2:0] j, input logic [15:0] v);
      int s;
      s = int'($signed(v));
      case (j)
         3'd0: return 1'b0;
         3'd1: return s > 0;
         3'd2: return s == 0;
         3'd3: return s >= 0;
         3'd4: return s < 0;
         3'd5: return s != 0;
         3'd6: return s <= 0;
         default: return 1'b1;
      endcase
   endfunction

   task automatic model_reset();
      mA = '0; mD = '0; mpc = '0; mhalt = 1'b0;
   endtask

   // Drives one instruction through fetch and any data phases, checking each cycle.
   task automatic run_instr(input logic [15:0] ins, input int fw, input int rw, input int ww,
                            input logic [15:0] rv);
      logic        is_c, need_rd, need_wr;
      logic [15:0] y, res;
      logic [14:0] npc;
      is_c    = ins[15];
      need_rd = is_c && ins[12];
      need_wr = is_c && ins[3];
      y       = ins[12] ? rv : mA;
      res     = comp_f(ins[11:6], mD, y);

      repeat (fw) begin
         @(negedge clk);
         chk("fetch_wait_req", instr_req, 1'b1);
         instr_valid = 1'b0;
         mem_ready   = 1'($urandom);
      end
      @(negedge clk);
      chk("fetch_req", instr_req, 1'b1);
      chk("fetch_addr", instr_addr, mpc);
      chk("pc", pc, mpc);
      instr_valid = 1'b1;
      instr_drv   = ins;
      mem_ready   = 1'($urandom);

      @(negedge clk);
      chk("exec_idle", {instr_req, mem_req, readM, writeM}, 4'b0000);
      instr_valid = 1'($urandom);
      instr_drv   = 16'($urandom);
      mem_ready   = 1'($urandom);

      if (need_rd) begin
         repeat (rw) begin
            @(negedge clk);
            chk("rd_wait", {mem_req, readM, writeM}, 3'b110);
            mem_ready   = 1'b0;
            instr_valid = 1'($urandom);
            inM         = 16'($urandom);
         end
         @(negedge clk);
         chk("rd", {mem_req, readM, writeM}, 3'b110);
         chk("rd_addr", addressM, mA[14:0]);
         mem_ready   = 1'b1;
         inM         = rv;
         instr_valid = 1'b0;
      end
      if (need_wr) begin
         repeat (ww) begin
            @(negedge clk);
            chk("wr_wait", {mem_req, readM, writeM}, 3'b101);
            chk("wr_wait_data", outM, res);
            mem_ready   = 1'b0;
            instr_valid = 1'($urandom);
         end
         @(negedge clk);
         chk("wr", {mem_req, readM, writeM}, 3'b101);
         chk("wr_addr", addressM, mA[14:0]);
         chk("wr_data", outM, res);
         mem_ready   = 1'b1;
         instr_valid = 1'b0;
      end

      if (!is_c) begin
         mA  = {1'b0, ins[14:0]};
         mpc = mpc + 15'd1;
      end else begin
         mhalt = (ins[2:0] == 3'b111) && (mA[14:0] == mpc);
         npc   = jump_f(ins[2:0], res) ? mA[14:0] : mpc + 15'd1;
         if (ins[5]) mA = res;
         if (ins[4]) mD = res;
         mpc = npc;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset       = 1'b1;
      instr_valid = 1'b0;
      mem_ready   = 1'b0;
      #1;
      chk("rst_req", {instr_req, mem_req, readM, writeM}, 4'b0000);
      chk("rst_halted", halted, 1'b0);
      chk("rst_pc", pc, 15'd0);
      chk("rst_outM", outM, 16'd0);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_release_req", instr_req, 1'b0);
      model_reset();
   endtask

   initial begin
      logic [15:0] ins;
      logic [2:0]  j;
      model_reset();
      do_reset();

      // @21, D=A, @100, M=D with zero wait
      run_instr(ainst(15'd21), 0, 0, 0, 16'd0);
      run_instr(cinst(1'b0, C_Y, 3'b010, 3'b000), 0, 0, 0, 16'd0);
      run_instr(ainst(15'd100), 0, 0, 0, 16'd0);
      run_instr(cinst(1'b0, C_X, 3'b001, 3'b000), 0, 0, 0, 16'd0);

      // @7, M=M+1 with two wait cycles on each phase
      run_instr(ainst(15'd7), 0, 0, 0, 16'd0);
      run_instr(cinst(1'b1, C_YP1, 3'b001, 3'b000), 0, 2, 2, 16'd41);

      // conditional jumps
      run_instr(cinst(1'b0, C_NEG1, 3'b010, 3'b000), 1, 0, 0, 16'd0);
      run_instr(ainst(15'd50), 0, 0, 0, 16'd0);
      run_instr(cinst(1'b0, C_X, 3'b000, 3'b100), 0, 0, 0, 16'd0);
      run_instr(cinst(1'b0, C_ZERO, 3'b010, 3'b000), 0, 0, 0, 16'd0);
      run_instr(cinst(1'b0, C_X, 3'b000, 3'b001), 0, 0, 0, 16'd0);
      run_instr(cinst(1'b0, C_X, 3'b000, 3'b011), 2, 0, 0, 16'd0);
      chk("jge_target", mpc, 15'd50);

      // pc wrap from 32767
      run_instr(ainst(15'd32767), 0, 0, 0, 16'd0);
      run_instr(cinst(1'b0, C_ZERO, 3'b000, 3'b111), 0, 0, 0, 16'd0);
      run_instr(cinst(1'b0, C_Y, 3'b010, 3'b000), 0, 0, 0, 16'd0);
      run_instr(cinst(1'b0, C_X, 3'b000, 3'b000), 0, 0, 0, 16'd0);

      // reset in the middle of a stalled write
      run_instr(ainst(15'd5), 0, 0, 0, 16'd0);
      @(negedge clk);
      chk("mid_fetch_req", instr_req, 1'b1);
      instr_valid = 1'b1;
      instr_drv   = cinst(1'b0, C_X, 3'b001, 3'b000);
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      chk("mid_wr", writeM, 1'b1);
      mem_ready = 1'b0;
      @(negedge clk);
      chk("mid_wr_hold", {mem_req, writeM}, 2'b11);
      reset = 1'b1;
      #1;
      chk("mid_rst_drop", {mem_req, writeM, readM}, 3'b000);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      run_instr(cinst(1'b0, C_X, 3'b001, 3'b000), 0, 0, 0, 16'd0);

      // halt at pc=12
      run_instr(ainst(15'd11), 0, 0, 0, 16'd0);
      run_instr(cinst(1'b0, C_ZERO, 3'b000, 3'b111), 0, 0, 0, 16'd0);
      run_instr(ainst(15'd12), 0, 0, 0, 16'd0);
      run_instr(cinst(1'b0, C_ZERO, 3'b000, 3'b111), 0, 0, 0, 16'd0);
      chk("model_halt", mhalt, 1'b1);
      @(negedge clk);
      chk("halted", halted, 1'b1);
      chk("halt_pc", pc, 15'd12);
      for (int i = 0; i < 20; i++) begin
         instr_valid = 1'b1;
         mem_ready   = 1'($urandom);
         @(negedge clk);
         chk("halt_quiet", {instr_req, mem_req, halted}, 3'b001);
      end
      do_reset();

      // random programs
      for (int k = 0; k < 200; k++) begin
         if ($urandom_range(0, 9) < 3) begin
            ins = ainst(15'($urandom));
         end else begin
            j = 3'($urandom);
            if (j == 3'b111 && mA[14:0] == mpc) j = 3'b000;
            ins = {1'b1, 2'($urandom), 1'($urandom), comps[$urandom_range(0, 17)], 3'($urandom), j};
         end
         run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                   16'($urandom));
      end
      @(negedge clk);
      chk("final_pc", pc, mpc);
      chk("final_halted", halted, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
